key_debounce_sync: RTL
======================

# key_debounce_sync

Input-conditioning stage that sits directly upstream of the synchronous D flip-flop block. It takes a raw, asynchronous, bouncing push-button or switch level and synchronizes it to `CLK`. It then qualifies the level with a stability counter and drives a clean debounced level, which feeds the flip-flop's `D` input, plus single-cycle edge pulses. All outputs are registered and glitch-free.

## Interface
Parameters:
- `CNT_W`, default 16: stability counter width.
- `STABLE_CYCLES`, default 1000: consecutive synchronized cycles a new level must hold. Legal range is 2 ≤ `STABLE_CYCLES` ≤ 2^`CNT_W`−1.

Ports:
- `CLK`, input, 1: single clock; all state updates on the rising edge.
- `RST_n`, input, 1: asynchronous, active-low reset.
- `KEY_IN`, input, 1: raw asynchronous input, may bounce.
- `KEY_LVL`, output, 1: debounced level; drives downstream `D`.
- `KEY_RISE`, output, 1: one-cycle pulse when `KEY_LVL` goes 0→1.
- `KEY_FALL`, output, 1: one-cycle pulse when `KEY_LVL` goes 1→0. Constant 0 unless the macro is defined (see Configuration).
- `BUSY`, output, 1: high while a candidate level change is being qualified.

## Operation
- Synchronizer:
  - Two flops: `s1 <= KEY_IN`, `s2 <= s1`.
  - Only `s2` is used downstream of the synchronizer.
- FSM states:
  - IDLE_LOW: stable low, `KEY_LVL`=0.
  - CHK_HIGH: qualifying a rise.
  - IDLE_HIGH: stable high, `KEY_LVL`=1.
  - CHK_LOW: qualifying a fall.
- Transitions:
  - IDLE_LOW and `s2`=1: go to CHK_HIGH, `cnt`<=0.
  - CHK_HIGH and `s2`=0: back to IDLE_LOW, `cnt`<=0. This is a bounce; no output change.
  - CHK_HIGH and `s2`=1 and `cnt`≠`STABLE_CYCLES`−1: `cnt`<=`cnt`+1.
  - CHK_HIGH and `s2`=1 and `cnt`=`STABLE_CYCLES`−1: go to IDLE_HIGH; `KEY_LVL`<=1, `KEY_RISE`<=1 for that one cycle.
  - The low side is symmetric: IDLE_HIGH goes to CHK_LOW on `s2`=0; CHK_LOW returns to IDLE_HIGH on `s2`=1; completion goes to IDLE_LOW with `KEY_LVL`<=0 and the `KEY_FALL` pulse.
- Counter:
  - Unsigned, `CNT_W` bits.
  - Never exceeds `STABLE_CYCLES`−1, so no wrap-around occurs.
  - Cleared on every entry to a CHK state and on abort.
- `BUSY` = (state is CHK_HIGH or CHK_LOW), registered with the state.
- `KEY_RISE` and `KEY_FALL`:
  - Registered and never high on consecutive cycles.
  - Never high simultaneously.
- Reset:
  - Asserting `RST_n`=0 at any time, including mid-qualification, immediately forces `s1`=`s2`=0, state IDLE_LOW, `cnt`=0, and `KEY_LVL`=`KEY_RISE`=`KEY_FALL`=`BUSY`=0.
- `KEY_IN` high across reset release:
  - Treated as a normal rise.
  - The `KEY_RISE` pulse follows after full qualification.

## Timing
- Reset values: `KEY_LVL`=0, `KEY_RISE`=0, `KEY_FALL`=0, `BUSY`=0.
- Latency: `KEY_IN` changes before rising edge 1 and then stays stable.
  - `s2` reflects the change after edge 2.
  - CHK is entered at edge 3, and `BUSY`=1 after edge 3.
  - `KEY_LVL` and the edge pulse update at edge `STABLE_CYCLES`+3.
  - `BUSY` falls at that same edge.
- Pulse width: exactly one `CLK` period.
- Bounce of one synchronized cycle or longer during CHK restarts qualification from zero on the next return.
- Pulses shorter than one `CLK` period may be missed. This is acceptable behaviour.

## Configuration
- `KEY_DEBOUNCE_FALL_PULSE_EN` defined:
  - `KEY_FALL` pulses as specified above.
- Not defined:
  - `KEY_FALL` is tied to 0.
  - The CHK_LOW→IDLE_LOW completion still clears `KEY_LVL` with identical timing.
  - All other behaviour is unchanged.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and a 10 ns `CLK`.
1. Reset state: hold `RST_n`=0 for 3 cycles with `KEY_IN`=1, then release → all outputs 0 during reset. `KEY_LVL`=1 and a single `KEY_RISE` appear at the 7th edge after release.
2. Clean press: `KEY_IN` 0→1 before edge 1 → `BUSY`=1 after edge 3. `KEY_LVL`=1 and `KEY_RISE`=1 after edge 7. `KEY_RISE`=0 after edge 8.
3. Bounce: `KEY_IN` toggles 1,0,1,0 every 2 cycles, then holds 1 → no `KEY_LVL` change during bouncing. `KEY_LVL`=1 exactly 7 edges after the final 0→1 transition.
4. Release with macro defined: `KEY_LVL`=1, `KEY_IN` 1→0 → `KEY_LVL`=0 and a one-cycle `KEY_FALL` after edge 7. Without the macro, `KEY_FALL` stays 0 and `KEY_LVL` timing is identical.
5. Reset mid-op: assert `RST_n`=0 asynchronously (between clock edges) while `BUSY`=1 with `cnt`=2 → outputs and `BUSY` clear immediately without waiting for an edge. After release with `KEY_IN`=1, full 7-edge requalification occurs.
6. Max count: `STABLE_CYCLES`=2^`CNT_W`−1 with `CNT_W`=4 (15) → `KEY_LVL` rises at edge 18 and `cnt` never wraps.

Source files
------------

// File: rtl/key_debounce_sync.sv
// Synchronizes and debounces a raw key level, giving a clean level, edge pulses and BUSY.
// Define KEY_DEBOUNCE_FALL_PULSE_EN to enable the KEY_FALL pulse (tied to 0 otherwise).
module key_debounce_sync #(
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic KEY_IN,
  output logic KEY_LVL,
  output logic KEY_RISE,
  output logic KEY_FALL,
  output logic BUSY
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_lvl;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;
  logic             w_lvl_next;
  logic             w_rise_next;
  logic             w_fall_next;
  logic             w_busy_next;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_s1    <= KEY_IN;
      r_s2    <= r_s1;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_lvl   <= w_lvl_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
      r_busy  <= w_busy_next;
    end
  end

  // Any return to the old level during a CHK state aborts and restarts qualification.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE_LOW: begin
        if (r_s2) begin
          w_state_next = CHK_HIGH;
          w_cnt_next   = '0;
        end
      end
      CHK_HIGH: begin
        if (!r_s2) begin
          w_state_next = IDLE_LOW;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE_HIGH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!r_s2) begin
          w_state_next = CHK_LOW;
          w_cnt_next   = '0;
        end
      end
      CHK_LOW: begin
        if (r_s2) begin
          w_state_next = IDLE_HIGH;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE_LOW;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE_LOW;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are derived from the upcoming state so they register alongside it.
  always_comb begin
    w_lvl_next  = (w_state_next == IDLE_HIGH) || (w_state_next == CHK_LOW);
    w_busy_next = (w_state_next == CHK_HIGH) || (w_state_next == CHK_LOW);
    w_rise_next = (r_state == CHK_HIGH) && (w_state_next == IDLE_HIGH);
`ifdef KEY_DEBOUNCE_FALL_PULSE_EN
    w_fall_next = (r_state == CHK_LOW) && (w_state_next == IDLE_LOW);
`else
    w_fall_next = 1'b0;
`endif
  end

  assign KEY_LVL  = r_lvl;
  assign KEY_RISE = r_rise;
  assign KEY_FALL = r_fall;
  assign BUSY     = r_busy;

endmodule
